// File: rtl/pulse_cmd_arbiter.sv
// pulse_cmd_arbiter: round-robin, burst-locked arbiter that feeds the single pulse-generator command FIFO.
// Optional macro PRIORITY_RESET_EN: in IDLE, a requester whose head word has opcode 0 wins ahead of round-robin.
module pulse_cmd_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_BURST   = 16,
    parameter int STALL_LIMIT = 64,
    parameter int MAX_OPCODE  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [32*NUM_REQ-1:0]      req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_afull,
    output logic                       fifo_wr_en,
    output logic [31:0]                fifo_wr_data,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       err_bad_cmd,
    output logic                       burst_trunc
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int RW = GW + 1;
    localparam int SW = $clog2(STALL_LIMIT + 1);

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [7:0]    burst_cnt_q, burst_cnt_d;
    logic [SW-1:0] stall_cnt_q, stall_cnt_d;
    logic          fifo_wr_en_q, fifo_wr_en_d;
    logic [31:0]   fifo_wr_data_q, fifo_wr_data_d;
    logic          err_q, err_d;
    logic          trunc_q, trunc_d;

    logic [31:0]   req_word [NUM_REQ];
    logic [31:0]   g_word;
    logic          g_valid;
    logic          g_last;
    logic          accept;
    logic [GW-1:0] rr_idx;
    logic [RW-1:0] rr_sum;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_word[i] = req_data[32*i +: 32];
        end
    end

    assign g_word  = req_word[grant_q];
    assign g_valid = req_valid[grant_q];
    assign g_last  = req_last[grant_q];
    assign accept  = |(req_valid & req_ready);

    // Walk from the farthest candidate to the nearest so the last hit is rr_ptr+1 first.
    always_comb begin
        rr_idx = rr_ptr_q;
        rr_sum = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            rr_sum = {1'b0, rr_ptr_q} + RW'(off);
            if (rr_sum >= RW'(NUM_REQ)) begin
                rr_sum = rr_sum - RW'(NUM_REQ);
            end
            if (req_valid[rr_sum[GW-1:0]]) begin
                rr_idx = rr_sum[GW-1:0];
            end
        end
    end

`ifdef PRIORITY_RESET_EN
    logic [GW-1:0] prio_idx;
    logic          prio_found;

    always_comb begin
        prio_found = 1'b0;
        prio_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (req_word[i][31:24] == 8'd0)) begin
                prio_found = 1'b1;
                prio_idx   = GW'(i);
            end
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= GW'(NUM_REQ - 1);
            grant_q        <= '0;
            burst_cnt_q    <= '0;
            stall_cnt_q    <= '0;
            fifo_wr_en_q   <= 1'b0;
            fifo_wr_data_q <= '0;
            err_q          <= 1'b0;
            trunc_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_q        <= grant_d;
            burst_cnt_q    <= burst_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
            fifo_wr_en_q   <= fifo_wr_en_d;
            fifo_wr_data_q <= fifo_wr_data_d;
            err_q          <= err_d;
            trunc_q        <= trunc_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_d        = grant_q;
        burst_cnt_d    = burst_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        fifo_wr_en_d   = 1'b0;
        fifo_wr_data_d = fifo_wr_data_q;
        err_d          = 1'b0;
        trunc_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
`ifdef PRIORITY_RESET_EN
                    if (prio_found) begin
                        grant_d = prio_idx;
                    end else begin
                        grant_d  = rr_idx;
                        rr_ptr_d = rr_idx;
                    end
`else
                    grant_d  = rr_idx;
                    rr_ptr_d = rr_idx;
`endif
                    burst_cnt_d = '0;
                    stall_cnt_d = '0;
                    state_d     = ST_BURST;
                end
            end

            ST_BURST: begin
                if (g_valid) begin
                    stall_cnt_d = '0;
                end else if (stall_cnt_q != SW'(STALL_LIMIT)) begin
                    stall_cnt_d = stall_cnt_q + SW'(1);
                end

                if (accept) begin
                    if (burst_cnt_q != 8'(MAX_BURST)) begin
                        burst_cnt_d = burst_cnt_q + 8'd1;
                    end
                    if (g_word[31:24] > 8'(MAX_OPCODE)) begin
                        err_d = 1'b1;
                    end else begin
                        fifo_wr_en_d   = 1'b1;
                        fifo_wr_data_d = g_word;
                    end
                    // req_last wins over a coinciding MAX_BURST, so no truncation flag then.
                    if (g_last) begin
                        state_d = ST_IDLE;
                    end else if (burst_cnt_d == 8'(MAX_BURST)) begin
                        state_d = ST_IDLE;
                        trunc_d = 1'b1;
                    end
                end else if (stall_cnt_d == SW'(STALL_LIMIT)) begin
                    state_d = ST_IDLE;
                    trunc_d = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready = '0;
        busy      = 1'b0;
        if (state_q == ST_BURST) begin
            req_ready[grant_q] = ~fifo_afull;
            busy               = 1'b1;
        end
    end

    assign fifo_wr_en   = fifo_wr_en_q;
    assign fifo_wr_data = fifo_wr_data_q;
    assign grant_id     = grant_q;
    assign err_bad_cmd  = err_q;
    assign burst_trunc  = trunc_q;

endmodule
